// File: rtl/cutting_pkg.sv
// Shared definitions for the resonance scan controller.
//   - Command codes carried on Din (0..20 are manual frequency points).
//   - Manual-map constants: setPoint = code * ManualScale + ManualBase.
//   - Scan FSM state enumeration.
package cutting_pkg;

    localparam logic [4:0] CmdManualMax = 5'd20;
    localparam logic [4:0] CmdRun       = 5'd21;
    localparam logic [4:0] CmdStop      = 5'd22;
    localparam logic [4:0] CmdSweepOn   = 5'd23;
    localparam logic [4:0] CmdSweepOff  = 5'd24;
    localparam logic [4:0] CmdPreset    = 5'd25;
    localparam logic [4:0] CmdScan      = 5'd26;

    localparam logic [14:0] ManualScale = 15'd224;
    localparam logic [14:0] ManualBase  = 15'd12460;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StSettle,
        StMeasure,
        StEval,
        StHandoff
    } scan_state_e;

    // ICO increment for a manual code, wrapping in 15 bits.
    function automatic logic [14:0] manual_inc(input logic [4:0] code);
        logic [14:0] prod;
        prod = 15'(code) * ManualScale;
        return prod + ManualBase;
    endfunction

endpackage

// File: rtl/theta_avg.sv
// Settle counter and phase accumulator for one scan point.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   settle_i         : controller is in SETTLE (discard samples)
//   measure_i        : controller is in MEASURE (accumulate samples)
//   theta_valid_i    : abs_theta_i carries a new sample
//   abs_theta_i      : phase count
//   settle_done_o    : combinational, last settle sample taken this cycle
//   sample_done_o    : combinational, last measure sample taken this cycle
//   avg_o            : accumulated sum >> AVG_LOG2
//   avg_valid_o      : one-cycle pulse the cycle after the last sample
module theta_avg
    import cutting_pkg::*;
#(
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       settle_i,
    input  logic       measure_i,
    input  logic       theta_valid_i,
    input  logic [7:0] abs_theta_i,
    output logic       settle_done_o,
    output logic       sample_done_o,
    output logic [7:0] avg_o,
    output logic       avg_valid_o
);

    localparam int unsigned SumW   = 8 + AVG_LOG2;
    localparam int unsigned NumAvg = 1 << AVG_LOG2;
    localparam int unsigned CntW   = 16;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SumW-1:0] sum_q, sum_d;
    logic            avg_valid_q, avg_valid_d;

    always_comb begin
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        avg_valid_d   = 1'b0;
        settle_done_o = 1'b0;
        sample_done_o = 1'b0;

        if (settle_i) begin
            if (SETTLE == 0) begin
                settle_done_o = 1'b1;
            end else if (theta_valid_i) begin
                if (cnt_q == CntW'(SETTLE - 1)) begin
                    settle_done_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Leaving SETTLE: measurement starts from an empty accumulator.
            if (settle_done_o) begin
                cnt_d = '0;
                sum_d = '0;
            end
        end else if (measure_i) begin
            if (theta_valid_i) begin
                sum_d = sum_q + SumW'(abs_theta_i);
                if (cnt_q == CntW'(NumAvg - 1)) begin
                    sample_done_o = 1'b1;
                    avg_valid_d   = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            // Any other state (or an abort) restarts the count.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            sum_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_o       = sum_q[AVG_LOG2 +: 8];
    assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/resonance_scan_ctrl.sv
// Resonance scan controller: manual frequency commands plus an automatic
// sweep that finds the ICO increment with the smallest V/I phase and hands it
// to the phase tracker.
// Ports:
//   clk40MHz    : clock, all logic on rising edge
//   rst         : synchronous active-high reset
//   cmd_valid   : Din holds a command this cycle
//   Din         : 5-bit command code
//   abs_theta   : phase count from the phase detector
//   theta_valid : abs_theta is new
//   setPoint    : ICO increment (open loop value / tracker seed)
//   stop        : force both gates low
//   Sweep       : 1 = open loop at setPoint, 0 = tracking enabled
//   busy        : scan running
//   scan_done   : one-cycle pulse on successful scan
//   fault       : sticky, no resonance found
//   cmd_err     : one-cycle pulse on rejected command
module resonance_scan_ctrl
    import cutting_pkg::*;
#(
    parameter logic [14:0] F_START   = 15'd12460,
    parameter logic [14:0] F_STEP    = 15'd56,
    parameter int unsigned N_STEPS   = 80,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned AVG_LOG2  = 3,
    parameter logic [7:0]  THETA_MAX = 8'd100
) (
    input  logic        clk40MHz,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [4:0]  Din,
    input  logic [7:0]  abs_theta,
    input  logic        theta_valid,
    output logic [14:0] setPoint,
    output logic        stop,
    output logic        Sweep,
    output logic        busy,
    output logic        scan_done,
    output logic        fault,
    output logic        cmd_err
);

    localparam logic [7:0] LastIdx = 8'(N_STEPS - 1);

    scan_state_e state_q, state_d;
    logic [14:0] setpoint_q, setpoint_d;
    logic        stop_q, stop_d;
    logic        sweep_q, sweep_d;
    logic        busy_q, busy_d;
    logic        scan_done_q, scan_done_d;
    logic        fault_q, fault_d;
    logic        cmd_err_q, cmd_err_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  best_theta_q, best_theta_d;
    logic [14:0] best_inc_q, best_inc_d;
    // Pending drop of Sweep one cycle after a successful handoff.
    logic        release_q, release_d;

    logic       scanning;
    logic       abort;
    logic       settle_en;
    logic       measure_en;
    logic       settle_done;
    logic       sample_done;
    logic [7:0] avg;
    logic       avg_valid;

    assign scanning = (state_q != StIdle);
    assign abort    = cmd_valid && scanning && ((Din == CmdStop) || (Din == CmdPreset));

    // An abort in the same cycle as a sample discards that sample.
    assign settle_en  = (state_q == StSettle) && !abort;
    assign measure_en = (state_q == StMeasure) && !abort;

    theta_avg #(
        .SETTLE   (SETTLE),
        .AVG_LOG2 (AVG_LOG2)
    ) u_theta_avg (
        .clk_i         (clk40MHz),
        .rst_i         (rst),
        .settle_i      (settle_en),
        .measure_i     (measure_en),
        .theta_valid_i (theta_valid),
        .abs_theta_i   (abs_theta),
        .settle_done_o (settle_done),
        .sample_done_o (sample_done),
        .avg_o         (avg),
        .avg_valid_o   (avg_valid)
    );

    always_comb begin
        state_d      = state_q;
        setpoint_d   = setpoint_q;
        stop_d       = stop_q;
        sweep_d      = sweep_q;
        busy_d       = busy_q;
        fault_d      = fault_q;
        idx_d        = idx_q;
        best_theta_d = best_theta_q;
        best_inc_d   = best_inc_q;
        scan_done_d  = 1'b0;
        cmd_err_d    = 1'b0;
        release_d    = 1'b0;

        // Scan sequencing
        if (abort) begin
            state_d = StIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (release_q) begin
                        sweep_d = 1'b0;
                    end
                end
                StStep: begin
                    setpoint_d = setpoint_q + F_STEP;
                    idx_d      = idx_q + 8'd1;
                    state_d    = StSettle;
                end
                StSettle: begin
                    if (settle_done) begin
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    if (sample_done) begin
                        state_d = StEval;
                    end
                end
                StEval: begin
                    // Strict compare: the earliest of equal minima is kept.
                    if (avg_valid && (avg < best_theta_q)) begin
                        best_theta_d = avg;
                        best_inc_d   = setpoint_q;
                    end
                    state_d = (idx_q < LastIdx) ? StStep : StHandoff;
                end
                StHandoff: begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                    if (best_theta_q <= THETA_MAX) begin
                        // Present the seed with Sweep still high, release next cycle.
                        setpoint_d  = best_inc_q;
                        sweep_d     = 1'b1;
                        scan_done_d = 1'b1;
                        release_d   = 1'b1;
                    end else begin
                        fault_d    = 1'b1;
                        stop_d     = 1'b1;
                        setpoint_d = F_START;
                        sweep_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Command decode; overrides the sequencing defaults above.
        if (cmd_valid) begin
            if (scanning && !abort) begin
                cmd_err_d = 1'b1;
            end else if (Din <= CmdManualMax) begin
                setpoint_d = manual_inc(Din);
            end else begin
                case (Din)
                    CmdRun:      stop_d  = 1'b0;
                    CmdStop:     stop_d  = 1'b1;
                    CmdSweepOn:  sweep_d = 1'b1;
                    CmdSweepOff: sweep_d = 1'b0;
                    CmdPreset: begin
                        setpoint_d = F_START;
                        stop_d     = 1'b0;
                        sweep_d    = 1'b1;
                        fault_d    = 1'b0;
                    end
                    CmdScan: begin
                        setpoint_d   = F_START;
                        sweep_d      = 1'b1;
                        stop_d       = 1'b0;
                        busy_d       = 1'b1;
                        fault_d      = 1'b0;
                        idx_d        = 8'd0;
                        best_theta_d = 8'hFF;
                        state_d      = StSettle;
                    end
                    default: cmd_err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            state_q      <= StIdle;
            setpoint_q   <= F_START;
            stop_q       <= 1'b1;
            sweep_q      <= 1'b1;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            fault_q      <= 1'b0;
            cmd_err_q    <= 1'b0;
            idx_q        <= 8'd0;
            best_theta_q <= 8'hFF;
            best_inc_q   <= F_START;
            release_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            setpoint_q   <= setpoint_d;
            stop_q       <= stop_d;
            sweep_q      <= sweep_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            fault_q      <= fault_d;
            cmd_err_q    <= cmd_err_d;
            idx_q        <= idx_d;
            best_theta_q <= best_theta_d;
            best_inc_q   <= best_inc_d;
            release_q    <= release_d;
        end
    end

    assign setPoint  = setpoint_q;
    assign stop      = stop_q;
    assign Sweep     = sweep_q;
    assign busy      = busy_q;
    assign scan_done = scan_done_q;
    assign fault     = fault_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: doc/resonance_scan_ctrl.md
RESONANCE_SCAN_CTRL -- requirements
Module: resonance_scan_ctrl

Interface
REQ-001 SHALL have parameter F_START, default 15'd12460, meaning first ICO increment of an auto-scan.
REQ-002 SHALL have parameter F_STEP, default 15'd56, meaning increment added per scan step.
REQ-003 SHALL have parameter N_STEPS, default 80, meaning number of scan points (range 1..255).
REQ-004 SHALL have parameter SETTLE, default 16, meaning theta_valid pulses discarded after each frequency change.
REQ-005 SHALL have parameter AVG_LOG2, default 3, meaning 2^AVG_LOG2 theta samples averaged per scan point.
REQ-006 SHALL have parameter THETA_MAX, default 8'd100, meaning the largest accepted best-point phase.
REQ-007 SHALL have port clk40MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port cmd_valid, input, 1 bit: qualifies Din for exactly one cycle.
REQ-010 SHALL have port Din, input, 5 bits: command code.
REQ-011 SHALL have port abs_theta, input, 8 bits: per-cycle V/I phase count from the phase detector.
REQ-012 SHALL have port theta_valid, input, 1 bit: one-cycle strobe, abs_theta is new.
REQ-013 SHALL have port setPoint, output, 15 bits: ICO increment used while Sweep=1 and as tracker seed.
REQ-014 SHALL have port stop, output, 1 bit: 1 forces both gates low.
REQ-015 SHALL have port Sweep, output, 1 bit: 1 means open loop at setPoint, 0 means phase tracking enabled.
REQ-016 SHALL have port busy, output, 1 bit: 1 while a scan is running.
REQ-017 SHALL have port scan_done, output, 1 bit: one-cycle pulse when a scan completes successfully.
REQ-018 SHALL have port fault, output, 1 bit: sticky; no resonance found.
REQ-019 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a command is rejected.

Function
REQ-020 SHALL act on Din only in cycles with cmd_valid=1.
REQ-021 SHALL set setPoint=Din*224+12460 (15-bit arithmetic) for codes 0..20.
REQ-022 SHALL decode code 21 as stop=0, 22 as stop=1, 23 as Sweep=1, 24 as Sweep=0.
REQ-023 SHALL decode code 25 as setPoint=F_START, stop=0, Sweep=1, fault=0.
REQ-024 SHALL decode code 26 as start auto-scan; codes 27..31 SHALL pulse cmd_err and change nothing else.
REQ-025 SHALL update every command effect on the cycle after the cmd_valid edge.
REQ-026 SHALL implement states IDLE, STEP, SETTLE, MEASURE, EVAL, HANDOFF.
REQ-027 On code 26 in IDLE, the block SHALL load F_START into setPoint, set Sweep=1, stop=0, busy=1, best_theta=8'hFF, clear fault and idx, and enter SETTLE.
REQ-028 SETTLE SHALL count SETTLE theta_valid pulses, then go to MEASURE with the accumulator cleared.
REQ-029 MEASURE SHALL sum 2^AVG_LOG2 samples into an (8+AVG_LOG2)-bit accumulator, then go to EVAL.
REQ-030 EVAL (1 cycle) SHALL form avg=sum>>AVG_LOG2 and, only if avg<best_theta (strict: first minimum wins ties), store best_theta=avg and best_inc=setPoint.
REQ-031 EVAL SHALL go to STEP if idx<N_STEPS-1, else to HANDOFF.
REQ-032 STEP (1 cycle) SHALL add F_STEP to setPoint and increment idx, then go to SETTLE.
REQ-033 HANDOFF SHALL, if best_theta<=THETA_MAX, set setPoint=best_inc, keep Sweep=1 for one cycle, set Sweep=0 on the next cycle, pulse scan_done, drop busy, and return to IDLE.
REQ-034 HANDOFF SHALL, if best_theta>THETA_MAX, set fault=1, stop=1, setPoint=F_START, Sweep=1, drop busy, and return to IDLE.
REQ-035 Codes 22 or 25 during a scan SHALL abort it: busy=0, return to IDLE, apply the code's normal effect.
REQ-036 All other codes during a scan (including 26) SHALL be ignored and pulse cmd_err.
REQ-037 A cmd_valid and theta_valid in the same cycle SHALL both be honoured; an abort discards that sample.
REQ-038 theta_valid SHALL be ignored in IDLE and HANDOFF.

Reset
REQ-039 rst=1 SHALL force IDLE, setPoint=F_START, stop=1, Sweep=1, busy=0, scan_done=0, fault=0, cmd_err=0, idx=0, best_theta=8'hFF, accumulators=0.
REQ-040 rst SHALL take priority over every command, including mid-scan; a scan in progress is discarded.

Structure
REQ-041 Command codes (0..26), the 224/12460 manual-map constants, and the state enumeration SHALL reside in shared package cutting_pkg.
REQ-042 SHALL contain one sub-module, theta_avg (settle counter + accumulator), producing a one-cycle avg_valid.

Verification
REQ-043 After reset, the bench SHALL send code 7 and expect setPoint=14028, stop=1, Sweep=1 unchanged.
REQ-044 The bench SHALL run code 26 with N_STEPS=4 and per-step abs_theta 50,30,30,60, and expect best_inc=12516, setPoint=12516, Sweep to fall 1 cycle after HANDOFF, and one scan_done pulse.
REQ-045 The bench SHALL run a scan with abs_theta fixed at 120, and expect fault=1, stop=1, setPoint=12460, no scan_done.
REQ-046 The bench SHALL send code 22 during MEASURE of step 2, and expect busy=0 and stop=1 next cycle, with setPoint holding the step-2 value.
REQ-047 The bench SHALL send code 5 and then code 30 mid-scan, and expect two cmd_err pulses and an unchanged scan result.
REQ-048 The bench SHALL assert rst during SETTLE, and expect all REQ-039 values next cycle, with a subsequent code 26 restarting from 12460.
